ddr_dimm_responder: RTL and testbench

- Cycle-based DDR4 DIMM responder. It is the memory-side counterpart of the controller: it decodes the command/address bus and tracks per-bank open rows.
- It captures write bursts after write latency and returns read bursts after read latency from an internal array.
- It sits below the controller in the testbench. It gives the bench a self-checking target and flags protocol violations.

---
 rtl/ddr_dimm_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_ddr_dimm_responder.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_dimm_responder.sv
// Cycle-based DDR4 DIMM responder: decodes the command bus, tracks open rows per bank and
// plays write/read bursts into and out of a local array after the programmed latencies.
module ddr_dimm_responder #(
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned ROW_BITS  = 2,
   parameter int unsigned COL_BITS  = 7,
   parameter int unsigned DLY_DEPTH = 32
) (
   input  logic              clock_t,
   input  logic              reset_n,
   input  logic              cs_n,
   input  logic              act_n,
   input  logic              ras_n_a16,
   input  logic              cas_n_a15,
   input  logic              we_n_a14,
   input  logic [1:0]        bg,
   input  logic [1:0]        ba,
   input  logic [13:0]       addr,
   input  logic [DATA_W-1:0] dq_in,
   output logic [DATA_W-1:0] dq_out,
   output logic              dq_oe,
   output logic              err_pulse,
   output logic [2:0]        err_code
);

   localparam int unsigned BASE_W = 4 + ROW_BITS + COL_BITS;
   localparam int unsigned IDX_W  = BASE_W + 3;
   localparam int unsigned DLY_W  = $clog2(DLY_DEPTH);

   typedef struct packed {
      logic              valid;
      logic              bl8;
      logic [BASE_W-1:0] base;
   } burst_t;

   logic [2:0]  rcw;
   logic        cmd_act, cmd_mrs, cmd_ref, cmd_pre, cmd_wr, cmd_rd;
   logic [3:0]  bank;
   logic [15:0] open_q;
   logic [13:0] row_q [16];
   logic        bank_open, any_open;

   logic [4:0]  cl_q, cwl_q, al;
   logic [1:0]  al_code_q, bl_code_q;
   logic [5:0]  rl, wl;
   logic        cmd_bl8;
   logic [BASE_W-1:0] cmd_base;

   burst_t rd_line_q [DLY_DEPTH];
   burst_t rd_line_d [DLY_DEPTH];
   burst_t wr_line_q [DLY_DEPTH];
   burst_t wr_line_d [DLY_DEPTH];
   logic   rd_accept, wr_accept, rd_sched_clash, wr_sched_clash;
   logic [DLY_W-1:0] rd_slot, wr_slot;

   logic [2:0]        rd_left_q, rd_beat_q, wr_left_q, wr_beat_q;
   logic [BASE_W-1:0] rd_base_q, wr_base_q;
   logic              rd_start, wr_start, rd_go, wr_go;
   logic [IDX_W-1:0]  rd_idx, wr_idx;

   logic [DATA_W-1:0] mem [1 << IDX_W];
   logic [DATA_W-1:0] dq_out_q;
   logic              dq_oe_q, err_pulse_q;
   logic [2:0]        err_code_q, err_hi;
   logic [6:1]        err_vec;

   assign rcw = {ras_n_a16, cas_n_a15, we_n_a14};

   always_comb begin
      cmd_act = 1'b0;
      cmd_mrs = 1'b0;
      cmd_ref = 1'b0;
      cmd_pre = 1'b0;
      cmd_wr  = 1'b0;
      cmd_rd  = 1'b0;
      if (!cs_n) begin
         if (!act_n) begin
            cmd_act = 1'b1;
         end else begin
            case (rcw)
               3'b000:  cmd_mrs = 1'b1;
               3'b001:  cmd_ref = 1'b1;
               3'b010:  cmd_pre = 1'b1;
               3'b100:  cmd_wr  = 1'b1;
               3'b101:  cmd_rd  = 1'b1;
               default: ;
            endcase
         end
      end
   end

   assign bank      = {bg, ba};
   assign bank_open = open_q[bank];
   assign any_open  = |open_q;
   assign cmd_base  = {bg, ba, row_q[bank][ROW_BITS-1:0], addr[3 +: COL_BITS]};

   always_comb begin
      case (al_code_q)
         2'b01:   al = cl_q - 5'd1;
         2'b10:   al = cl_q - 5'd2;
         default: al = 5'd0;
      endcase
      rl = {1'b0, cl_q} + {1'b0, al};
      wl = {1'b0, cwl_q} + {1'b0, al};
      case (bl_code_q)
         2'b10:   cmd_bl8 = 1'b0;
         2'b01:   cmd_bl8 = addr[12];
         default: cmd_bl8 = 1'b1;
      endcase
   end

   assign rd_accept = cmd_rd && bank_open;
   assign wr_accept = cmd_wr && bank_open;
   // Output beats are registered, so a read is queued one slot earlier than a write.
   assign rd_slot   = DLY_W'(rl - 6'd2);
   assign wr_slot   = DLY_W'(wl - 6'd1);

   always_comb begin
      for (int i = 0; i < int'(DLY_DEPTH) - 1; i++) begin
         rd_line_d[i] = rd_line_q[i+1];
         wr_line_d[i] = wr_line_q[i+1];
      end
      rd_line_d[DLY_DEPTH-1] = '0;
      wr_line_d[DLY_DEPTH-1] = '0;
      rd_sched_clash = 1'b0;
      wr_sched_clash = 1'b0;
      if (rd_accept && (int'(rl) - 2 < int'(DLY_DEPTH))) begin
         rd_sched_clash     = rd_line_d[rd_slot].valid;
         rd_line_d[rd_slot] = '{valid: 1'b1, bl8: cmd_bl8, base: cmd_base};
      end
      if (wr_accept && (int'(wl) - 1 < int'(DLY_DEPTH))) begin
         wr_sched_clash     = wr_line_d[wr_slot].valid;
         wr_line_d[wr_slot] = '{valid: 1'b1, bl8: cmd_bl8, base: cmd_base};
      end
   end

   assign rd_start = rd_line_q[0].valid;
   assign wr_start = wr_line_q[0].valid;
   assign rd_go    = rd_start || (rd_left_q != 3'd0);
   assign wr_go    = wr_start || (wr_left_q != 3'd0);
   assign rd_idx   = rd_start ? {rd_line_q[0].base, 3'd0} : {rd_base_q, rd_beat_q};
   assign wr_idx   = wr_start ? {wr_line_q[0].base, 3'd0} : {wr_base_q, wr_beat_q};

   always_comb begin
      err_vec[1] = cmd_act && bank_open;
      err_vec[2] = cmd_ref && any_open;
      err_vec[3] = (cmd_rd || cmd_wr) && !bank_open;
      err_vec[4] = rd_sched_clash || wr_sched_clash ||
                   (rd_start && (rd_left_q != 3'd0)) || (wr_start && (wr_left_q != 3'd0));
      err_vec[5] = cmd_mrs && any_open;
      err_vec[6] = dq_oe_q && wr_go;
      err_hi     = 3'd0;
      for (int i = 1; i <= 6; i++) begin
         if (err_vec[i]) err_hi = 3'(i);
      end
   end

   always_ff @(posedge clock_t) begin
      if (!reset_n) begin
         open_q    <= '0;
         cl_q      <= 5'd10;
         cwl_q     <= 5'd9;
         al_code_q <= 2'b00;
         bl_code_q <= 2'b00;
         for (int i = 0; i < int'(DLY_DEPTH); i++) begin
            rd_line_q[i] <= '0;
            wr_line_q[i] <= '0;
         end
         rd_left_q   <= '0;
         rd_beat_q   <= '0;
         rd_base_q   <= '0;
         wr_left_q   <= '0;
         wr_beat_q   <= '0;
         wr_base_q   <= '0;
         dq_oe_q     <= 1'b0;
         dq_out_q    <= '0;
         err_pulse_q <= 1'b0;
         err_code_q  <= 3'd0;
      end else begin
         rd_line_q <= rd_line_d;
         wr_line_q <= wr_line_d;

         if (cmd_act && !bank_open) open_q[bank] <= 1'b1;
         if (cmd_pre) begin
            if (addr[10]) open_q <= '0;
            else          open_q[bank] <= 1'b0;
         end
         if (cmd_mrs) begin
            case (ba)
               2'd0: begin
                  bl_code_q <= addr[1:0];
                  cl_q      <= 5'd9 + {2'b00, addr[6:4]};
               end
               2'd1:    al_code_q <= addr[4:3];
               2'd2:    cwl_q     <= 5'd9 + {2'b00, addr[5:3]};
               default: ;
            endcase
         end

         // A new start always preempts whatever is left of the previous burst.
         if (rd_start) begin
            rd_base_q <= rd_line_q[0].base;
            rd_beat_q <= 3'd1;
            rd_left_q <= rd_line_q[0].bl8 ? 3'd7 : 3'd3;
         end else if (rd_left_q != 3'd0) begin
            rd_beat_q <= rd_beat_q + 3'd1;
            rd_left_q <= rd_left_q - 3'd1;
         end
         if (wr_start) begin
            wr_base_q <= wr_line_q[0].base;
            wr_beat_q <= 3'd1;
            wr_left_q <= wr_line_q[0].bl8 ? 3'd7 : 3'd3;
         end else if (wr_left_q != 3'd0) begin
            wr_beat_q <= wr_beat_q + 3'd1;
            wr_left_q <= wr_left_q - 3'd1;
         end

         dq_oe_q <= rd_go;
         if (rd_go) dq_out_q <= mem[rd_idx];
         err_pulse_q <= |err_vec;
         if (|err_vec) err_code_q <= err_hi;
      end
   end

   // Array and row storage survive reset.
   always_ff @(posedge clock_t) begin
      if (reset_n && cmd_act && !bank_open) row_q[bank] <= addr;
      if (reset_n && wr_go) mem[wr_idx] <= dq_in;
   end

   assign dq_out    = dq_out_q;
   assign dq_oe     = dq_oe_q;
   assign err_pulse = err_pulse_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_ddr_dimm_responder.sv
// Directed bench for ddr_dimm_responder: command sequences with hand-computed beat timing,
// burst data, and error codes.
module tb_ddr_dimm_responder;

   localparam int unsigned DATA_W = 64;
   localparam logic [3:0] C_ACT = 4'b0111;
   localparam logic [3:0] C_MRS = 4'b1000;
   localparam logic [3:0] C_REF = 4'b1001;
   localparam logic [3:0] C_PRE = 4'b1010;
   localparam logic [3:0] C_WR  = 4'b1100;
   localparam logic [3:0] C_RD  = 4'b1101;

   logic              clock_t = 1'b0;
   logic              reset_n;
   logic              cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14;
   logic [1:0]        bg, ba;
   logic [13:0]       addr;
   logic [DATA_W-1:0] dq_in;
   logic [DATA_W-1:0] dq_out;
   logic              dq_oe, err_pulse;
   logic [2:0]        err_code;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;
   int                oe_cyc [$];
   logic [DATA_W-1:0] oe_dat [$];
   int                err_cyc [$];

   ddr_dimm_responder #(
      .DATA_W   (DATA_W),
      .ROW_BITS (2),
      .COL_BITS (7),
      .DLY_DEPTH(32)
   ) dut (
      .clock_t  (clock_t),
      .reset_n  (reset_n),
      .cs_n     (cs_n),
      .act_n    (act_n),
      .ras_n_a16(ras_n_a16),
      .cas_n_a15(cas_n_a15),
      .we_n_a14 (we_n_a14),
      .bg       (bg),
      .ba       (ba),
      .addr     (addr),
      .dq_in    (dq_in),
      .dq_out   (dq_out),
      .dq_oe    (dq_oe),
      .err_pulse(err_pulse),
      .err_code (err_code)
   );

   always #5 clock_t = ~clock_t;
   always @(posedge clock_t) cyc <= cyc + 1;

   // Record every driven beat and error pulse with the cycle it appears in.
   always @(negedge clock_t) begin
      if (dq_oe === 1'b1) begin
         oe_cyc.push_back(cyc);
         oe_dat.push_back(dq_out);
      end
      if (err_pulse === 1'b1) err_cyc.push_back(cyc);
   end

   task automatic tick();
      @(posedge clock_t);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic clear_mon();
      oe_cyc.delete();
      oe_dat.delete();
      err_cyc.delete();
   endtask

   task automatic cmd(input logic [3:0] c, input logic [1:0] g, input logic [1:0] b,
                      input logic [13:0] a, output int k);
      k    = cyc;
      cs_n = 1'b0;
      {act_n, ras_n_a16, cas_n_a15, we_n_a14} = c;
      bg   = g;
      ba   = b;
      addr = a;
      tick();
      cs_n = 1'b1;
      {act_n, ras_n_a16, cas_n_a15, we_n_a14} = 4'b1111;
      addr = '0;
   endtask

   task automatic wr_burst(input int k, input int wl, input logic [DATA_W-1:0] start,
                           input logic [DATA_W-1:0] step);
      while (cyc < k + wl) tick();
      for (int i = 0; i < 8; i++) begin
         dq_in = start + step * DATA_W'(i);
         tick();
      end
      dq_in = '0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle(3);
      n_checks++;
      if (dq_oe !== 1'b0) begin
         n_fail++; $display("FAIL reset_dq_oe: got %b want 0", dq_oe);
      end
      n_checks++;
      if (dq_out !== '0) begin
         n_fail++; $display("FAIL reset_dq_out: got %h want 0", dq_out);
      end
      n_checks++;
      if (err_pulse !== 1'b0) begin
         n_fail++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse);
      end
      n_checks++;
      if (err_code !== 3'd0) begin
         n_fail++; $display("FAIL reset_err_code: got %0d want 0", err_code);
      end
      reset_n = 1'b1;
      idle(2);
   endtask

   task automatic test_write_read();
      int k, r;
      logic [DATA_W-1:0] exp;
      clear_mon();
      cmd(C_ACT, 2'd0, 2'd0, 14'd5, k);
      idle(9);
      cmd(C_WR, 2'd0, 2'd0, 14'h000, k);
      wr_burst(k, 9, 64'h11, 64'h11);
      idle(3);
      cmd(C_RD, 2'd0, 2'd0, 14'h000, r);
      idle(20);
      n_checks++;
      if (oe_cyc.size() != 8) begin
         n_fail++; $display("FAIL wr_rd_beats: got %0d want 8", oe_cyc.size());
      end
      if (oe_cyc.size() >= 8) begin
         n_checks++;
         if (oe_cyc[0] != r + 10) begin
            n_fail++; $display("FAIL wr_rd_first: got %0d want %0d", oe_cyc[0], r + 10);
         end
         n_checks++;
         if (oe_cyc[7] != r + 17) begin
            n_fail++; $display("FAIL wr_rd_last: got %0d want %0d", oe_cyc[7], r + 17);
         end
         for (int i = 0; i < 8; i++) begin
            exp = 64'h11 * DATA_W'(i + 1);
            n_checks++;
            if (oe_dat[i] !== exp) begin
               n_fail++; $display("FAIL wr_rd_data[%0d]: got %h want %h", i, oe_dat[i], exp);
            end
         end
      end
      n_checks++;
      if (err_cyc.size() != 0) begin
         n_fail++; $display("FAIL wr_rd_err: got %0d pulses want 0", err_cyc.size());
      end
   endtask

   task automatic test_latency();
      int k, r;
      clear_mon();
      cmd(C_PRE, 2'd0, 2'd0, 14'h400, k);
      cmd(C_MRS, 2'd0, 2'd0, 14'h030, k);
      cmd(C_MRS, 2'd0, 2'd1, 14'h008, k);
      cmd(C_ACT, 2'd1, 2'd2, 14'd1, k);
      idle(2);
      cmd(C_RD, 2'd1, 2'd2, 14'h000, r);
      idle(35);
      n_checks++;
      if (oe_cyc.size() != 8) begin
         n_fail++; $display("FAIL lat_beats: got %0d want 8", oe_cyc.size());
      end
      if (oe_cyc.size() > 0) begin
         n_checks++;
         if (oe_cyc[0] != r + 23) begin
            n_fail++; $display("FAIL lat_first: got %0d want %0d", oe_cyc[0], r + 23);
         end
      end
      n_checks++;
      if (err_cyc.size() != 0) begin
         n_fail++; $display("FAIL lat_err: got %0d pulses want 0", err_cyc.size());
      end
   endtask

   task automatic test_burst_chop();
      int k, r;
      clear_mon();
      cmd(C_PRE, 2'd0, 2'd0, 14'h400, k);
      cmd(C_MRS, 2'd0, 2'd0, 14'h011, k);
      cmd(C_MRS, 2'd0, 2'd1, 14'h000, k);
      cmd(C_ACT, 2'd0, 2'd0, 14'd5, k);
      idle(2);
      cmd(C_RD, 2'd0, 2'd0, 14'h0000, r);
      idle(20);
      n_checks++;
      if (oe_cyc.size() != 4) begin
         n_fail++; $display("FAIL bc4_beats: got %0d want 4", oe_cyc.size());
      end
      if (oe_cyc.size() >= 4) begin
         n_checks++;
         if (oe_cyc[0] != r + 10 || oe_dat[3] !== 64'h44) begin
            n_fail++;
            $display("FAIL bc4_timing: got cyc %0d data %h want cyc %0d data 44",
                     oe_cyc[0], oe_dat[3], r + 10);
         end
      end
      clear_mon();
      cmd(C_RD, 2'd0, 2'd0, 14'h1000, r);
      idle(20);
      n_checks++;
      if (oe_cyc.size() != 8) begin
         n_fail++; $display("FAIL otf_bl8_beats: got %0d want 8", oe_cyc.size());
      end
      if (oe_cyc.size() >= 8) begin
         n_checks++;
         if (oe_dat[7] !== 64'h88) begin
            n_fail++; $display("FAIL otf_bl8_data: got %h want 88", oe_dat[7]);
         end
      end
      n_checks++;
      if (err_cyc.size() != 0) begin
         n_fail++; $display("FAIL chop_err: got %0d pulses want 0", err_cyc.size());
      end
   endtask

   task automatic test_back_to_back();
      int k, r, s;
      logic [DATA_W-1:0] exp;
      cmd(C_PRE, 2'd0, 2'd0, 14'h400, k);
      cmd(C_MRS, 2'd0, 2'd0, 14'h010, k);
      cmd(C_ACT, 2'd0, 2'd0, 14'd5, k);
      idle(2);
      cmd(C_WR, 2'd0, 2'd0, 14'h008, k);
      wr_burst(k, 9, 64'hA1, 64'h1);
      idle(3);
      clear_mon();
      cmd(C_RD, 2'd0, 2'd0, 14'h000, r);
      idle(3);
      cmd(C_RD, 2'd0, 2'd0, 14'h008, k);
      idle(25);
      n_checks++;
      if (oe_cyc.size() != 12) begin
         n_fail++; $display("FAIL clash_beats: got %0d want 12", oe_cyc.size());
      end
      if (oe_cyc.size() >= 12) begin
         n_checks++;
         if (oe_cyc[0] != r + 10 || oe_cyc[11] != r + 21) begin
            n_fail++;
            $display("FAIL clash_span: got %0d..%0d want %0d..%0d",
                     oe_cyc[0], oe_cyc[11], r + 10, r + 21);
         end
         for (int i = 0; i < 12; i++) begin
            exp = (i < 4) ? 64'h11 * DATA_W'(i + 1) : 64'hA1 + DATA_W'(i - 4);
            n_checks++;
            if (oe_dat[i] !== exp) begin
               n_fail++; $display("FAIL clash_data[%0d]: got %h want %h", i, oe_dat[i], exp);
            end
         end
      end
      n_checks++;
      if (err_cyc.size() != 1 || err_code !== 3'd4) begin
         n_fail++;
         $display("FAIL clash_err: got %0d pulses code %0d want 1 pulse code 4",
                  err_cyc.size(), err_code);
      end
      if (err_cyc.size() > 0) begin
         n_checks++;
         if (err_cyc[0] != r + 14) begin
            n_fail++; $display("FAIL clash_err_cyc: got %0d want %0d", err_cyc[0], r + 14);
         end
      end
      clear_mon();
      cmd(C_RD, 2'd0, 2'd0, 14'h000, s);
      idle(7);
      cmd(C_RD, 2'd0, 2'd0, 14'h008, k);
      idle(30);
      n_checks++;
      if (oe_cyc.size() != 16) begin
         n_fail++; $display("FAIL b2b_beats: got %0d want 16", oe_cyc.size());
      end
      if (oe_cyc.size() >= 16) begin
         n_checks++;
         if (oe_cyc[0] != s + 10 || oe_cyc[15] != s + 25) begin
            n_fail++;
            $display("FAIL b2b_span: got %0d..%0d want %0d..%0d",
                     oe_cyc[0], oe_cyc[15], s + 10, s + 25);
         end
         n_checks++;
         if (oe_dat[7] !== 64'h88 || oe_dat[8] !== 64'hA1) begin
            n_fail++;
            $display("FAIL b2b_data: got %h,%h want 88,a1", oe_dat[7], oe_dat[8]);
         end
      end
      n_checks++;
      if (err_cyc.size() != 0) begin
         n_fail++; $display("FAIL b2b_err: got %0d pulses want 0", err_cyc.size());
      end
   endtask

   task automatic test_errors();
      int k, r, w;
      clear_mon();
      cmd(C_ACT, 2'd0, 2'd0, 14'd9, k);
      idle(2);
      n_checks++;
      if (err_cyc.size() != 1 || err_code !== 3'd1) begin
         n_fail++;
         $display("FAIL act_open: got %0d pulses code %0d want 1 pulse code 1",
                  err_cyc.size(), err_code);
      end
      clear_mon();
      cmd(C_MRS, 2'd0, 2'd3, 14'h000, k);
      idle(2);
      n_checks++;
      if (err_cyc.size() != 1 || err_code !== 3'd5) begin
         n_fail++;
         $display("FAIL mrs_open: got %0d pulses code %0d want 1 pulse code 5",
                  err_cyc.size(), err_code);
      end
      clear_mon();
      cmd(C_RD, 2'd3, 2'd3, 14'h000, k);
      idle(20);
      n_checks++;
      if (err_cyc.size() != 1 || err_code !== 3'd3 || oe_cyc.size() != 0) begin
         n_fail++;
         $display("FAIL rd_closed: got %0d pulses code %0d beats %0d want 1 pulse code 3 beats 0",
                  err_cyc.size(), err_code, oe_cyc.size());
      end
      clear_mon();
      cmd(C_REF, 2'd0, 2'd0, 14'h000, k);
      idle(2);
      n_checks++;
      if (err_cyc.size() != 1 || err_code !== 3'd2) begin
         n_fail++;
         $display("FAIL ref_open: got %0d pulses code %0d want 1 pulse code 2",
                  err_cyc.size(), err_code);
      end
      // Read and write bursts landing on the same cycles.
      clear_mon();
      cmd(C_RD, 2'd0, 2'd0, 14'h000, r);
      cmd(C_WR, 2'd0, 2'd0, 14'h010, w);
      wr_burst(w, 9, 64'hC1, 64'h1);
      idle(5);
      n_checks++;
      if (err_cyc.size() != 8 || err_code !== 3'd6) begin
         n_fail++;
         $display("FAIL bus_conflict: got %0d pulses code %0d want 8 pulses code 6",
                  err_cyc.size(), err_code);
      end
      n_checks++;
      if (oe_cyc.size() != 8) begin
         n_fail++; $display("FAIL conflict_beats: got %0d want 8", oe_cyc.size());
      end
      if (oe_cyc.size() > 0 && err_cyc.size() > 0) begin
         n_checks++;
         if (oe_dat[0] !== 64'h11 || err_cyc[0] != r + 11) begin
            n_fail++;
            $display("FAIL conflict_read: got %h at err cyc %0d want 11 at %0d",
                     oe_dat[0], err_cyc[0], r + 11);
         end
      end
      clear_mon();
      cmd(C_RD, 2'd0, 2'd0, 14'h010, r);
      idle(20);
      n_checks++;
      if (oe_cyc.size() != 8) begin
         n_fail++; $display("FAIL conflict_wr_beats: got %0d want 8", oe_cyc.size());
      end
      if (oe_cyc.size() >= 8) begin
         n_checks++;
         if (oe_dat[0] !== 64'hC1 || oe_dat[7] !== 64'hC8) begin
            n_fail++;
            $display("FAIL conflict_wr_kept: got %h,%h want c1,c8", oe_dat[0], oe_dat[7]);
         end
      end
      clear_mon();
      cmd(C_PRE, 2'd0, 2'd0, 14'h400, k);
      cmd(C_REF, 2'd0, 2'd0, 14'h000, k);
      idle(3);
      n_checks++;
      if (err_cyc.size() != 0) begin
         n_fail++; $display("FAIL ref_closed: got %0d pulses want 0", err_cyc.size());
      end
   endtask

   task automatic test_reset_mid_burst();
      int k, r, m;
      clear_mon();
      cmd(C_MRS, 2'd0, 2'd0, 14'h030, k);
      cmd(C_MRS, 2'd0, 2'd1, 14'h008, k);
      cmd(C_ACT, 2'd0, 2'd0, 14'd5, k);
      idle(2);
      cmd(C_RD, 2'd0, 2'd0, 14'h000, r);
      while (cyc < r + 25) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      n_checks++;
      if (dq_oe !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_oe: got %b want 0", dq_oe);
      end
      n_checks++;
      if (oe_cyc.size() != 3) begin
         n_fail++; $display("FAIL rst_mid_pre_beats: got %0d want 3", oe_cyc.size());
      end
      if (oe_cyc.size() > 0) begin
         n_checks++;
         if (oe_cyc[0] != r + 23) begin
            n_fail++; $display("FAIL rst_mid_first: got %0d want %0d", oe_cyc[0], r + 23);
         end
      end
      clear_mon();
      idle(30);
      n_checks++;
      if (oe_cyc.size() != 0 || err_code !== 3'd0) begin
         n_fail++;
         $display("FAIL rst_mid_abort: got %0d beats code %0d want 0 beats code 0",
                  oe_cyc.size(), err_code);
      end
      cmd(C_ACT, 2'd0, 2'd0, 14'd5, k);
      idle(2);
      cmd(C_RD, 2'd0, 2'd0, 14'h000, m);
      idle(20);
      n_checks++;
      if (oe_cyc.size() != 8) begin
         n_fail++; $display("FAIL rst_mode_beats: got %0d want 8", oe_cyc.size());
      end
      if (oe_cyc.size() > 0) begin
         n_checks++;
         if (oe_cyc[0] != m + 10 || oe_dat[0] !== 64'h11) begin
            n_fail++;
            $display("FAIL rst_mode_rl: got cyc %0d data %h want cyc %0d data 11",
                     oe_cyc[0], oe_dat[0], m + 10);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset_n   = 1'b0;
      cs_n      = 1'b1;
      act_n     = 1'b1;
      ras_n_a16 = 1'b1;
      cas_n_a15 = 1'b1;
      we_n_a14  = 1'b1;
      bg        = '0;
      ba        = '0;
      addr      = '0;
      dq_in     = '0;
      test_reset();
      test_write_read();
      test_latency();
      test_burst_chop();
      test_back_to_back();
      test_errors();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
